one_hot_demux_buf: RTL and testbench
====================================

Name: one_hot_demux_buf

Overview:
- Packet-level demultiplexer: steers a flit stream from one input to one of PORT_NUM output ports. This is the distribute side of the NoC's one-hot gather mux.
- The destination is given as a binary port index on the head flit. The block decodes it to one-hot, locks the route until the tail flit, and buffers one flit per output port.
- Sits between the crossbar input stage and the per-port output channels.

Parameters:
- PORT_NUM, 5, number of output ports (>=2).
- DATA_WIDTH, 32, flit payload width.
- SEL_WIDTH, log2(PORT_NUM), width of the binary destination index. Derived; do not override.

Ports:
- clk  input  1  single clock domain; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  DATA_WIDTH  flit payload.
- in_sel  input  SEL_WIDTH  binary destination port; sampled only on an accepted head flit.
- in_head  input  1  flit is the first flit of a packet.
- in_tail  input  1  flit is the last flit of a packet (head and tail both high = single-flit packet).
- in_valid  input  1  input flit valid.
- in_ready  output  1  block accepts the flit this cycle.
- out_data  output  PORT_NUM*DATA_WIDTH  per-port payload; port i occupies bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH].
- out_tail  output  PORT_NUM  per-port tail marker of the buffered flit.
- out_valid  output  PORT_NUM  per-port buffered flit valid.
- out_ready  input  PORT_NUM  per-port downstream ready.
- route_onehot  output  PORT_NUM  currently locked route, one-hot; all zero when unlocked.
- err  output  1  one-cycle pulse on a protocol error.

Behaviour:
- Reset (asynchronous, immediate):
  - out_valid, out_tail, out_data, route_onehot and err go to 0; state goes to IDLE.
  - Flits in flight are discarded.
  - After reset deasserts, operation resumes on the next rising edge.
- Handshakes:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer on port i occurs when out_valid[i] && out_ready[i].
- Per-port buffer: one register stage per port.
  - Full port i accepts a new flit in the same cycle it drains (out_ready[i] high), so throughput is 1 flit/cycle.
  - Latency from input transfer to out_valid high is 1 cycle.
- Target port p:
  - In IDLE: p = decoded in_sel.
  - In ROUTE: p = the latched route.
- in_ready:
  - IDLE / ROUTE: in_ready = ~out_valid[p] | out_ready[p].
  - IDLE with in_sel >= PORT_NUM: in_ready = 1.
  - DROP: in_ready = 1.
  - in_ready is combinational from out_ready and state; it never depends on in_valid.
- State machine (IDLE, ROUTE, DROP):
  - IDLE, accepted head, in_sel < PORT_NUM: write the flit to port in_sel and set route_onehot to the one-hot decode of in_sel. If in_tail=0, go to ROUTE; if in_tail=1, stay IDLE and leave route_onehot at 0.
  - IDLE, accepted head, in_sel >= PORT_NUM: flit discarded, err pulses. If in_tail=0, go to DROP; if in_tail=1, stay IDLE.
  - IDLE, accepted non-head flit: flit discarded, err pulses, stay IDLE.
  - ROUTE, accepted flit: write it to the locked port; in_sel is ignored. A flit with in_head=1 is still forwarded, and err pulses. When in_tail=1, clear route_onehot and go to IDLE.
  - DROP: consume and discard flits until the tail, then go to IDLE. No err pulses in DROP.
- Simultaneous events:
  - Same-port write and drain in one cycle: the register takes the new flit and out_valid stays 1.
  - Ports other than p drain independently every cycle.
- Stall: with in_valid=1 and in_ready=0, no state change occurs, and the held in_data/in_sel are re-evaluated each cycle.
- err is registered and is 1 for exactly one cycle, the cycle after the offending transfer.

Test Plan:
- Reset, then a single head+tail flit with in_sel=3, data 0xA5A5_0001 -> cycle+1: out_valid=5'b01000, out_data port3=0xA5A5_0001, out_tail[3]=1; route_onehot stays 0.
- 4-flit packet to port 1, all out_ready=1 -> in_ready held 1; route_onehot=5'b00010 from flit 1 until the tail is accepted; 4 consecutive out_valid[1] beats in order; in_sel changes mid-packet are ignored.
- Backpressure: out_ready[2]=0 with a 3-flit packet to port 2 -> flit 1 buffered, in_ready=0 while the port stays full; raising out_ready[2] resumes at 1 flit/cycle with no loss or duplication.
- Head with in_sel=6, 3-flit packet -> err pulses once, all 3 flits consumed, no out_valid on any port, state returns to IDLE.
- Non-head flit in IDLE -> discarded, err=1 for one cycle. Then a head flit in ROUTE -> flit forwarded to the locked port, err pulses.
- Reset asserted mid-packet with port 0 full -> out_valid=0 and route_onehot=0 immediately, without waiting for a clock edge; the next head flit routes normally.

Source files
------------

// File: rtl/one_hot_demux_buf.sv
// Packet demultiplexer: steers a flit stream to one of PORT_NUM outputs by a
// binary index on the head flit. The route stays locked until the tail, and each port has one register stage.
module one_hot_demux_buf #(
    parameter int PORT_NUM   = 5,
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = $clog2(PORT_NUM)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [DATA_WIDTH-1:0]          in_data,
    input  logic [SEL_WIDTH-1:0]           in_sel,
    input  logic                           in_head,
    input  logic                           in_tail,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [PORT_NUM*DATA_WIDTH-1:0] out_data,
    output logic [PORT_NUM-1:0]            out_tail,
    output logic [PORT_NUM-1:0]            out_valid,
    input  logic [PORT_NUM-1:0]            out_ready,
    output logic [PORT_NUM-1:0]            route_onehot,
    output logic                           err
);

    typedef enum logic [1:0] {IDLE, ROUTE, DROP} state_t;

    state_t                  state_q;
    logic [PORT_NUM-1:0]     route_q;
    logic                    err_q;
    logic [PORT_NUM-1:0]     valid_q;
    logic [PORT_NUM-1:0]     tail_q;
    logic [DATA_WIDTH-1:0]   data_q [PORT_NUM];

    logic                    sel_ok;
    logic [PORT_NUM-1:0]     sel_onehot;
    logic [PORT_NUM-1:0]     target;
    logic [PORT_NUM-1:0]     port_free;
    logic [PORT_NUM-1:0]     wr_en;
    logic                    accept;
    logic                    fwd;

    // Widened by one bit so the range check also works when PORT_NUM is a power of two.
    assign sel_ok = ({1'b0, in_sel} < (SEL_WIDTH+1)'(PORT_NUM));

    genvar gi;
    generate
        for (gi = 0; gi < PORT_NUM; gi++) begin : g_decode
            assign sel_onehot[gi] = (in_sel == SEL_WIDTH'(gi));
        end
    endgenerate

    always_comb begin
        target = '0;
        case (state_q)
            IDLE:    target = sel_onehot;
            ROUTE:   target = route_q;
            default: target = '0;
        endcase
    end

    assign port_free = ~valid_q | out_ready;
    assign in_ready  = (state_q == DROP) || ((state_q == IDLE) && !sel_ok) || |(target & port_free);
    assign accept    = in_valid && in_ready;
    assign fwd       = accept && (((state_q == IDLE) && in_head && sel_ok) || (state_q == ROUTE));
    assign wr_en     = {PORT_NUM{fwd}} & target;

    generate
        for (gi = 0; gi < PORT_NUM; gi++) begin : g_port
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    valid_q[gi] <= 1'b0;
                    tail_q[gi]  <= 1'b0;
                    data_q[gi]  <= '0;
                end else if (wr_en[gi]) begin
                    valid_q[gi] <= 1'b1;
                    tail_q[gi]  <= in_tail;
                    data_q[gi]  <= in_data;
                end else if (out_ready[gi]) begin
                    valid_q[gi] <= 1'b0;
                end
            end
            assign out_data[gi*DATA_WIDTH +: DATA_WIDTH] = data_q[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            route_q <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (accept) begin
                case (state_q)
                    IDLE: begin
                        if (in_head && sel_ok) begin
                            if (!in_tail) begin
                                state_q <= ROUTE;
                                route_q <= sel_onehot;
                            end
                        end else begin
                            err_q <= 1'b1;
                            if (in_head && !in_tail) state_q <= DROP;
                        end
                    end
                    ROUTE: begin
                        // A stray head inside a packet is still forwarded, only flagged.
                        err_q <= in_head;
                        if (in_tail) begin
                            route_q <= '0;
                            state_q <= IDLE;
                        end
                    end
                    DROP: begin
                        if (in_tail) state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign out_valid    = valid_q;
    assign out_tail     = tail_q;
    assign route_onehot = route_q;
    assign err          = err_q;

endmodule

// File: tb/tb_one_hot_demux_buf.sv
// Directed bench for one_hot_demux_buf: per-port expected-flit queues filled on
// input acceptance and drained by a monitor on every output transfer.
module tb_one_hot_demux_buf;

    localparam int P  = 5;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic [DW-1:0]     in_data;
    logic [2:0]        in_sel;
    logic              in_head;
    logic              in_tail;
    logic              in_valid;
    logic              in_ready;
    logic [P*DW-1:0]   out_data;
    logic [P-1:0]      out_tail;
    logic [P-1:0]      out_valid;
    logic [P-1:0]      out_ready;
    logic [P-1:0]      route_onehot;
    logic              err;

    int tests = 0;
    int fails = 0;
    int stall_cnt = 0;
    logic [DW:0] exp_q [P][$];

    one_hot_demux_buf #(.PORT_NUM(P), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_sel(in_sel),
        .in_head(in_head), .in_tail(in_tail), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_tail(out_tail), .out_valid(out_valid), .out_ready(out_ready),
        .route_onehot(route_onehot), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor: every transfer must match the oldest expected flit of its port.
    always @(negedge clk) begin
        for (int p = 0; p < P; p++) begin
            if (out_valid[p] && out_ready[p]) begin
                if (exp_q[p].size() == 0) begin
                    check($sformatf("unexpected_out_p%0d", p), {31'd0, out_tail[p], out_data[p*DW +: DW]}, 64'h0);
                end else begin
                    logic [DW:0] e;
                    e = exp_q[p].pop_front();
                    $display("[TB] port %0d out data=%08h tail=%0b", p, out_data[p*DW +: DW], out_tail[p]);
                    check($sformatf("out_data_p%0d", p), 64'(out_data[p*DW +: DW]), 64'(e[DW-1:0]));
                    check($sformatf("out_tail_p%0d", p), 64'(out_tail[p]), 64'(e[DW]));
                end
            end
        end
    end

    // Drive one flit, wait for acceptance, then check err/route after the accepting edge.
    task automatic send(input logic [DW-1:0] d, input int sel, input bit h, input bit t,
                        input int exp_port, input bit exp_err, input logic [P-1:0] exp_route);
        int  waited = 0;
        bit  ok = 1'b0;
        in_data  = d;
        in_sel   = 3'(sel);
        in_head  = h;
        in_tail  = t;
        in_valid = 1'b1;
        while (!ok && waited < 100) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            else begin
                waited++;
                @(posedge clk);
                #1;
            end
        end
        tests++;
        assert (ok) else begin
            fails++;
            $error("FAIL accept_timeout: observed in_ready=%0b after %0d cycles expected 1", in_ready, waited);
        end
        if (!ok) begin
            in_valid = 1'b0;
            return;
        end
        stall_cnt += waited;
        if (exp_port >= 0) exp_q[exp_port].push_back({t, d});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        $display("[TB] in data=%08h sel=%0d head=%0b tail=%0b err=%0b route=%05b", d, sel, h, t, err, route_onehot);
        check("err", 64'(err), 64'(exp_err));
        check("route_onehot", 64'(route_onehot), 64'(exp_route));
    endtask

    initial begin
        reset = 1'b1; in_data = '0; in_sel = '0; in_head = 0; in_tail = 0; in_valid = 0;
        out_ready = '1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_out_valid", 64'(out_valid), 64'h0);
        check("rst_route", 64'(route_onehot), 64'h0);
        check("rst_err", 64'(err), 64'h0);
        check("rst_in_ready", 64'(in_ready), 64'h1);

        // Single-flit packet to port 3
        send(32'hA5A5_0001, 3, 1, 1, 3, 0, 5'b00000);
        check("single_out_valid", 64'(out_valid), 64'b01000);
        check("single_out_data", 64'(out_data[3*DW +: DW]), 64'hA5A5_0001);
        check("single_out_tail", 64'(out_tail[3]), 64'h1);

        // 4-flit packet to port 1 with in_sel wandering after the head
        stall_cnt = 0;
        send(32'h1111_0001, 1, 1, 0, 1, 0, 5'b00010);
        send(32'h1111_0002, 4, 0, 0, 1, 0, 5'b00010);
        send(32'h1111_0003, 0, 0, 0, 1, 0, 5'b00010);
        send(32'h1111_0004, 2, 0, 1, 1, 0, 5'b00000);
        check("pkt1_no_stall", 64'(stall_cnt), 64'h0);

        // Backpressure on port 2
        out_ready = 5'b11011;
        send(32'h2222_0001, 2, 1, 0, 2, 0, 5'b00100);
        in_data = 32'h2222_0002; in_sel = 3'd5; in_head = 0; in_tail = 0; in_valid = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready", 64'(in_ready), 64'h0);
            check("bp_held_data", 64'(out_data[2*DW +: DW]), 64'h2222_0001);
            @(posedge clk);
            #1;
        end
        out_ready = '1;
        stall_cnt = 0;
        send(32'h2222_0002, 5, 0, 0, 2, 0, 5'b00100);
        send(32'h2222_0003, 5, 0, 1, 2, 0, 5'b00000);
        check("bp_resume_no_stall", 64'(stall_cnt), 64'h0);

        // Out-of-range destination: whole packet dropped, one err pulse
        send(32'h6666_0001, 6, 1, 0, -1, 1, 5'b00000);
        send(32'h6666_0002, 1, 0, 0, -1, 0, 5'b00000);
        send(32'h6666_0003, 1, 0, 1, -1, 0, 5'b00000);

        // Non-head in IDLE, then a stray head inside a packet to port 4
        send(32'h5555_0001, 0, 0, 0, -1, 1, 5'b00000);
        send(32'h5555_0002, 4, 1, 0, 4, 0, 5'b10000);
        send(32'h5555_0003, 1, 1, 0, 4, 1, 5'b10000);
        send(32'h5555_0004, 1, 0, 1, 4, 0, 5'b00000);

        // Asynchronous reset mid-packet with port 0 full
        out_ready = 5'b11110;
        send(32'h7777_0001, 0, 1, 0, 0, 0, 5'b00001);
        check("pre_rst_valid0", 64'(out_valid[0]), 64'h1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_valid", 64'(out_valid), 64'h0);
        check("async_rst_route", 64'(route_onehot), 64'h0);
        exp_q[0].delete();
        @(posedge clk);
        #1 reset = 1'b0;
        out_ready = '1;
        send(32'h7777_0002, 0, 1, 1, 0, 0, 5'b00000);

        repeat (4) @(posedge clk);
        #1;
        for (int p = 0; p < P; p++)
            check($sformatf("drain_empty_p%0d", p), 64'(exp_q[p].size()), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
